// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer
//   Sits between the ps2_keyboard receive FIFO and the display/ASCII logic.
//   Pops one FIFO byte at a time (IDLE -> POP -> SETTLE), parses set-2 framing
//   (0xE0 extended prefix, 0xF0 break prefix) into one-cycle make/break events,
//   tracks the currently held key and keeps a BCD count of new presses.
//
// Ports
//   clk          system clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   ready        FIFO non-empty
//   data[7:0]    FIFO head byte
//   overflow     FIFO overflow flag
//   clr_ovf      synchronous clear of ovf_sticky (overflow wins if both high)
//   nextdata_n   active-low pop strobe, low for exactly the POP cycle
//   key_valid    one-cycle event pulse qualifying key_code/key_ext/key_make
//   key_code     scan code of the event, prefixes stripped (held until next event)
//   key_ext      event was preceded by 0xE0
//   key_make     1 = press/repeat, 0 = release
//   key_repeat   pulse with key_valid: make of the already-held key
//   held_valid   a key is currently held
//   held_code    code of the held key (0 when none)
//   press_count  BCD count of new presses, wraps all-9s -> 0
//   ovf_sticky   latched overflow indication

module ps2_scan_sequencer #(
  parameter int unsigned CNT_DIGITS = 2,
  parameter int unsigned SETTLE_CYC = 1   // legal range 1..3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ready,
  input  logic [7:0]              data,
  input  logic                    overflow,
  input  logic                    clr_ovf,
  output logic                    nextdata_n,
  output logic                    key_valid,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_make,
  output logic                    key_repeat,
  output logic                    held_valid,
  output logic [7:0]              held_code,
  output logic [4*CNT_DIGITS-1:0] press_count,
  output logic                    ovf_sticky
);

  localparam int unsigned CW = 4 * CNT_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_SETTLE
  } state_e;

  state_e          state_q;
  logic [1:0]      settle_q;
  logic [7:0]      byte_q;
  logic            ext_q;
  logic            brk_q;
  logic            nextdata_n_q;
  logic            key_valid_q;
  logic [7:0]      key_code_q;
  logic            key_ext_q;
  logic            key_make_q;
  logic            key_repeat_q;
  logic            held_valid_q;
  logic [7:0]      held_code_q;
  logic            held_ext_q;
  logic [CW-1:0]   press_q;
  logic            ovf_q;

  logic            is_drop;
  logic            held_match;
  logic [CW-1:0]   press_inc;

  // Ripple BCD increment: each digit wraps 9->0 and carries into the next.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < CNT_DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    is_drop    = (byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                 (byte_q == 8'hEE) || (byte_q == 8'hE1);
    // Held key identity includes the extended flag.
    held_match = held_valid_q && (held_ext_q == ext_q) && (held_code_q == byte_q);
    press_inc  = bcd_inc(press_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      byte_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_make_q   <= 1'b0;
      key_repeat_q <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      press_q      <= '0;
    end else begin
      key_valid_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ready) begin
            byte_q       <= data;
            nextdata_n_q <= 1'b0;
            state_q      <= S_POP;
          end
        end
        S_POP: begin
          nextdata_n_q <= 1'b1;
          settle_q     <= '0;
          state_q      <= S_SETTLE;
          if (byte_q == 8'hE0) begin
            ext_q <= 1'b1;
          end else if (byte_q == 8'hF0) begin
            brk_q <= 1'b1;
          end else if (is_drop) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end else begin
            key_valid_q <= 1'b1;
            key_code_q  <= byte_q;
            key_ext_q   <= ext_q;
            key_make_q  <= !brk_q;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            if (!brk_q) begin
              if (held_match) begin
                key_repeat_q <= 1'b1;
              end else begin
                held_valid_q <= 1'b1;
                held_code_q  <= byte_q;
                held_ext_q   <= ext_q;
                press_q      <= press_inc;
              end
            end else if (held_match) begin
              held_valid_q <= 1'b0;
              held_code_q  <= '0;
              held_ext_q   <= 1'b0;
            end
          end
        end
        S_SETTLE: begin
          if (settle_q == 2'(SETTLE_CYC - 1)) begin
            state_q <= S_IDLE;
          end else begin
            settle_q <= settle_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (overflow) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_make    = key_make_q;
  assign key_repeat  = key_repeat_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign press_count = press_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Testbench for ps2_scan_sequencer: a FIFO model feeds bytes, and a byte-level
// reference model predicts every make/break event, held key and press count.

module tb_ps2_scan_sequencer;

  localparam int unsigned CNT_DIGITS = 2;
  localparam int unsigned SETTLE_CYC = 1;
  localparam int unsigned CW         = 4 * CNT_DIGITS;

  logic          clk;
  logic          rst;
  logic          ready;
  logic [7:0]    data;
  logic          overflow;
  logic          clr_ovf;
  logic          nextdata_n;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_make;
  logic          key_repeat;
  logic          held_valid;
  logic [7:0]    held_code;
  logic [CW-1:0] press_count;
  logic          ovf_sticky;

  ps2_scan_sequencer #(
    .CNT_DIGITS(CNT_DIGITS),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .data       (data),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .nextdata_n (nextdata_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_make   (key_make),
    .key_repeat (key_repeat),
    .held_valid (held_valid),
    .held_code  (held_code),
    .press_count(press_count),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    code;
    logic          ext;
    logic          make;
    logic          rep;
    logic [CW-1:0] cnt;
    logic          hv;
    logic [7:0]    hc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         pop_cyc[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state
  bit         m_ext, m_brk, m_hv;
  logic [8:0] m_held;
  int         m_cnt;
  ev_t        last_ev;

  function automatic logic [CW-1:0] to_bcd(input int n);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CNT_DIGITS); i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_hv = 0; m_held = '0; m_cnt = 0;
    exp_q.delete();
    last_ev = '{8'h00, 1'b0, 1'b0, 1'b0, '0, 1'b0, 8'h00};
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hE1) begin
      m_ext = 0; m_brk = 0;
    end else begin
      e.code = b; e.ext = m_ext; e.make = !m_brk; e.rep = 0;
      if (!m_brk) begin
        if (m_hv && m_held == {m_ext, b}) e.rep = 1;
        else begin
          m_hv = 1; m_held = {m_ext, b};
          m_cnt = (m_cnt + 1) % (10 ** CNT_DIGITS);
        end
      end else if (m_hv && m_held == {m_ext, b}) begin
        m_hv = 0; m_held = '0;
      end
      e.cnt = to_bcd(m_cnt); e.hv = m_hv; e.hc = m_held[7:0];
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic fifo_upd();
    ready = (fifo.size() != 0);
    data  = ready ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
    fifo_upd();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fifo.delete();
    fifo_upd();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs until the FIFO drains and every predicted event is seen (bounded).
  task automatic run(input int max_cyc);
    int  cyc, quiet, pops, want_pops;
    ev_t e;
    cyc = 0; quiet = 0; pops = 0;
    want_pops = fifo.size();
    pop_cyc.delete();
    while (cyc < max_cyc && !(fifo.size() == 0 && exp_q.size() == 0 && quiet >= 4)) begin
      @(negedge clk);
      cyc++;
      if (!nextdata_n) begin
        pops++;
        pop_cyc.push_back(cyc);
        if (fifo.size() != 0) void'(fifo.pop_front());
        fifo_upd();
        quiet = 0;
      end else quiet++;
      if (key_valid) begin
        if (exp_q.size() == 0) chk("spurious_event", key_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("ev_code", key_code, e.code);
          chk("ev_ext", key_ext, e.ext);
          chk("ev_make", key_make, e.make);
          chk("ev_repeat", key_repeat, e.rep);
          chk("ev_count", press_count, e.cnt);
          chk("ev_held_valid", held_valid, e.hv);
          chk("ev_held_code", held_code, e.hc);
          last_ev = e;
        end
      end else if (key_repeat) chk("stray_repeat", key_repeat, 0);
    end
    chk("pending_events", exp_q.size(), 0);
    chk("pop_count", pops, want_pops);
    chk("hold_code", key_code, last_ev.code);
    chk("hold_ext", key_ext, last_ev.ext);
    chk("hold_make", key_make, last_ev.make);
    chk("held_valid", held_valid, m_hv);
    chk("held_code", held_code, m_held[7:0]);
    chk("press_count", press_count, to_bcd(m_cnt));
  endtask

  initial begin
    logic [7:0] pool[4];
    logic [7:0] drops[4];
    logic [7:0] code;
    int         r;
    bit         ext;

    drops[0] = 8'hAA; drops[1] = 8'hFA; drops[2] = 8'hEE; drops[3] = 8'hE1;
    rst = 1'b0; ready = 1'b0; data = 8'h00; overflow = 1'b0; clr_ovf = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_held_valid", held_valid, 0);
    chk("rst_press_count", press_count, 0);
    chk("rst_ovf", ovf_sticky, 0);
    rst = 1'b1;

    // Single key
    push(8'h1C);
    run(200);
    chk("single_count", press_count, 8'h01);

    // Full press/release
    do_reset();
    push(8'h1C); push(8'hF0); push(8'h1C);
    run(200);

    // Extended key
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    run(200);

    // Typematic repeat
    push(8'h23); push(8'h23); push(8'h23); push(8'hF0); push(8'h23);
    run(200);

    // Back-to-back bytes with ready held high
    push(8'h2B); push(8'hF0); push(8'h2B); push(8'h1A); push(8'hF0); push(8'h1A);
    run(300);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("pop_spacing", pop_cyc[i] - pop_cyc[i-1], 2 + SETTLE_CYC);

    // Count wrap: 100 distinct press/release pairs
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      push(8'(i)); push(8'hF0); push(8'(i));
      run(200);
      if (i == 99)  chk("count_99", press_count, 8'h99);
      if (i == 100) chk("count_wrap", press_count, 8'h00);
    end

    // Randomized byte streams
    for (int k = 0; k < 300; k++) begin
      pool[0] = 8'h1C; pool[1] = 8'h23; pool[2] = 8'h75;
      pool[3] = 8'($urandom_range(1, 8'h7F));
      code = pool[$urandom_range(0, 3)];
      ext  = bit'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      if (r < 5) begin
        if (ext) push(8'hE0);
        push(code);
      end else if (r < 8) begin
        if (ext) push(8'hE0);
        push(8'hF0); push(code);
      end else if (r == 8) begin
        push(drops[$urandom_range(0, 3)]);
      end else begin
        push(ext ? 8'hE0 : 8'hF0);
        push(drops[$urandom_range(0, 3)]);
      end
      if (k % 20 == 19) run(2000);
    end

    // Overflow sticky: set wins over clear, clear works alone
    @(negedge clk); overflow = 1'b1; clr_ovf = 1'b1;
    @(negedge clk); overflow = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", ovf_sticky, 1);
    @(negedge clk);
    chk("ovf_hold", ovf_sticky, 1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_clear", ovf_sticky, 0);
    overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;

    // Async reset during POP: immediate reset values, no event, no pop
    push(8'h3B);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nextdata_n) break;
    end
    chk("pop_reached", nextdata_n, 0);
    rst = 1'b0;
    #1;
    chk("arst_nextdata_n", nextdata_n, 1);
    chk("arst_key_valid", key_valid, 0);
    chk("arst_key_code", key_code, 0);
    chk("arst_key_make", key_make, 0);
    chk("arst_held_valid", held_valid, 0);
    chk("arst_held_code", held_code, 0);
    chk("arst_press_count", press_count, 0);
    chk("arst_ovf", ovf_sticky, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_event", key_valid, 0);
    end
    rst = 1'b1;
    // The aborted byte was never popped, so it is processed afresh.
    model_byte(8'h3B);
    run(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
Controller that sits between the ps2_keyboard receive FIFO and the display/ASCII logic. It owns the FIFO pop handshake (nextdata_n) and walks each byte through a fetch/pop/settle sequence. It parses PS/2 set-2 framing (0xE0 extended prefix, 0xF0 break prefix) into clean one-cycle make/break events. It also tracks the currently held key and keeps a BCD press counter, so downstream logic never has to interpret raw scan bytes.

Parameters:
CNT_DIGITS, 2, number of BCD digits in press_count; the count wraps from all-9s to 0.
SETTLE_CYC, 1, idle cycles after each pop before ready is sampled again (covers the FIFO pointer update); legal range 1..3.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst  in  1  asynchronous active-low reset.
ready  in  1  FIFO non-empty, from ps2_keyboard.
data  in  8  FIFO head byte, from ps2_keyboard.
overflow  in  1  FIFO overflow flag, from ps2_keyboard.
clr_ovf  in  1  synchronous clear of ovf_sticky.
nextdata_n  out  1  active-low pop strobe to the FIFO.
key_valid  out  1  one-cycle pulse: key_code/key_ext/key_make are valid.
key_code  out  8  scan code of the event, prefix bytes stripped.
key_ext  out  1  event was preceded by 0xE0.
key_make  out  1  1 = press/repeat, 0 = release.
key_repeat  out  1  qualifies key_valid: make of the already-held code (typematic repeat).
held_valid  out  1  a key is currently held.
held_code  out  8  code of the held key.
press_count  out  4*CNT_DIGITS  BCD count of new presses.
ovf_sticky  out  1  latched overflow indication.

Behaviour:
- Reset (rst=0, async): state=IDLE, nextdata_n=1, key_valid=0, key_code=0, key_ext=0, key_make=0, key_repeat=0, held_valid=0, held_code=0, press_count=0, ovf_sticky=0, ext/brk prefix flags=0. Reset asserted mid-sequence aborts it with no event and no pop.
- FSM states: IDLE, POP, SETTLE.
- IDLE: if ready=1, latch data into byte_r, then go to POP. Otherwise stay in IDLE.
- POP: lasts exactly 1 cycle. nextdata_n=0 (registered, so low only in this cycle). byte_r is decoded here. Go to SETTLE.
- SETTLE: lasts SETTLE_CYC cycles with nextdata_n=1, then returns to IDLE.
- Pop spacing: exactly one pop per byte; minimum byte-to-byte interval is 2+SETTLE_CYC cycles. ready is ignored outside IDLE.
- Decode of byte_r in POP (results registered, visible in the first SETTLE cycle):
  - 0xE0: set ext flag; no event.
  - 0xF0: set brk flag; no event.
  - 0xAA, 0xFA, 0xEE, 0xE1 (BAT/ack/echo/pause lead): drop the byte, clear both flags, no event.
  - Any other byte: key_valid=1 for one cycle; key_code=byte_r; key_ext=ext flag; key_make=!brk flag. Both flags then clear.
- Make handling:
  - If held_valid=1 and {key_ext,key_code} equals the held key: key_repeat=1; press_count unchanged.
  - Otherwise: key_repeat=0; held key is replaced by the new key; held_valid=1; press_count increments.
- Break handling:
  - If the code matches the held key (code and ext flag): held_valid=0 and held_code=0.
  - Otherwise the held key is unchanged.
  - key_repeat=0 on every break.
- press_count: BCD ripple increment; each digit wraps 9->0 with carry. For CNT_DIGITS=2 the count runs 99 -> 00.
- Output hold: key_code, key_ext and key_make hold their values until the next event. key_valid and key_repeat are pulses.
- ovf_sticky: set on any cycle with overflow=1; cleared by clr_ovf=1. If both are asserted in the same cycle, set wins. The parser state is not flushed on overflow.

Test Plan:
- Reset then single key: FIFO holds 0x1C -> nextdata_n low exactly one cycle; key_valid pulse with key_code=0x1C, key_ext=0, key_make=1; press_count=0x01; held_code=0x1C.
- Full press/release 0x1C,0xF0,0x1C -> 3 pops; events make then break; held_valid ends 0; press_count=0x01.
- Extended key E0 75, E0 F0 75 -> 2 events, both key_code=0x75 with key_ext=1; no events for prefix bytes; press_count increments once.
- Typematic 0x23 x3 then F0 23 -> first make has key_repeat=0, next two have key_repeat=1; press_count +1 total.
- Wrap: 100 distinct press/release pairs from count 0 -> press_count=0x00 after the 100th press, 0x99 after the 99th.
- Back-to-back FIFO bytes (ready held high), SETTLE_CYC=1 -> pops spaced exactly 3 cycles. Async rst pulse during POP -> all outputs at reset values immediately, and no key_valid is emitted.
